// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time program loader for the pipelined MIPS core. It takes a byte stream
// from a host link, assembles big-endian 32-bit words and writes them to
// consecutive instruction-memory word addresses. The core is held in reset
// until the whole image has been received (and, optionally, checksum-verified).
//
// Frame: N_HI, N_LO (16-bit word count), 4*N payload bytes (MSB first per
// word), then an optional CSUM byte (XOR of all payload bytes).
//
// Optional feature macro: IMEM_LOADER_CSUM_EN
//   defined   -> frame carries CSUM, the CHK state and the XOR register exist
//   undefined -> no CSUM byte; RUN follows one cycle after the last write
//
// Ports
//   CLK         clock, rising edge
//   RST         synchronous reset, active-high
//   byte_valid  host byte available
//   byte_data   host byte
//   byte_ready  loader accepts a byte (transfer on byte_valid & byte_ready)
//   imem_we     instruction-memory write strobe, one cycle per word
//   imem_addr   word address of the write
//   imem_wdata  word to write
//   core_rst    reset to the MIPS core, high until the load succeeds
//   done        load completed successfully (sticky)
//   err         load failed (sticky)
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst,
   output logic              done,
   output logic              err
);

`ifdef IMEM_LOADER_CSUM_EN
   typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, CHK, RUN, FAIL} loadState_t;
`else
   typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, FLUSH, RUN, FAIL} loadState_t;
`endif

   localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

   loadState_t  state, nextState;
   logic        armed;       // low for the cycle after reset so byte_ready stays 0
   logic        take;        // byte handshake this cycle
   logic [1:0]  byteCnt;
   logic [7:0]  countHi;
   logic [15:0] wordCount;
   logic [23:0] asmReg;      // first three bytes of the word being assembled
   logic        lastWord;
   logic [15:0] newCount;
`ifdef IMEM_LOADER_CSUM_EN
   logic [7:0]  runXor;
`endif

   assign newCount = {countHi, byte_data};
   // imem_addr already holds the index of the word being assembled, because it
   // advances at the end of the previous word's write cycle.
   assign lastWord = ((17'(imem_addr) + 17'd1) == {1'b0, wordCount});

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= HDR_HI;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState  = state;
      byte_ready = 1'b0;
      core_rst   = 1'b1;
      done       = 1'b0;
      err        = 1'b0;
      take       = 1'b0;

      case (state)
         HDR_HI, HDR_LO, DATA, FAIL: byte_ready = armed;
`ifdef IMEM_LOADER_CSUM_EN
         CHK:                        byte_ready = armed;
`endif
         default:                    byte_ready = 1'b0;
      endcase
      take = byte_valid & byte_ready;

      case (state)
         HDR_HI: if (take) nextState = HDR_LO;
         HDR_LO: begin
            if (take) begin
               if ({1'b0, newCount} > CAPACITY) begin
                  nextState = FAIL;
               end else if (newCount == 16'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
                  nextState = CHK;
`else
                  nextState = RUN;
`endif
               end else begin
                  nextState = DATA;
               end
            end
         end
         DATA: begin
            if (take && byteCnt == 2'd3 && lastWord) begin
`ifdef IMEM_LOADER_CSUM_EN
               nextState = CHK;
`else
               nextState = FLUSH;
`endif
            end
         end
`ifdef IMEM_LOADER_CSUM_EN
         CHK: if (take) nextState = (byte_data == runXor) ? RUN : FAIL;
`else
         // Lets the final write pulse complete before the core leaves reset.
         FLUSH: nextState = RUN;
`endif
         RUN: begin
            core_rst = 1'b0;
            done     = 1'b1;
         end
         FAIL: err = 1'b1;
         default: nextState = HDR_HI;
      endcase
   end

   // Control and output registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         armed      <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         byteCnt    <= 2'd0;
`ifdef IMEM_LOADER_CSUM_EN
         runXor     <= 8'd0;
`endif
      end else begin
         armed   <= 1'b1;
         imem_we <= 1'b0;
         // Hold at the top address so a full-capacity load never wraps.
         if (imem_we && imem_addr != '1) begin
            imem_addr <= imem_addr + ADDR_W'(1);
         end
         if (take && state == DATA) begin
            byteCnt <= byteCnt + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
            runXor  <= runXor ^ byte_data;
`endif
            if (byteCnt == 2'd3) begin
               imem_we    <= 1'b1;
               imem_wdata <= {asmReg, byte_data};
            end
         end
      end
   end

   // Frame data registers; only meaningful once loaded by a handshake
   always_ff @(posedge CLK) begin
      if (take) begin
         case (state)
            HDR_HI:  countHi   <= byte_data;
            HDR_LO:  wordCount <= newCount;
            DATA:    asmReg    <= {asmReg[15:0], byte_data};
            default: ;
         endcase
      end
   end

endmodule
